// File: rtl/spram_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM with a 2-entry register output buffer.
// Optional SPF_BYPASS_EN: pushes into an empty pipeline go straight to the output buffer.
module spram_fifo_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW+1:0]    count,
  output logic             ram_ceb,
  output logic             ram_web,
  output logic [AW-1:0]    ram_a,
  output logic [WIDTH-1:0] ram_d,
  input  logic [WIDTH-1:0] ram_q
);

  localparam logic [AW:0] mem_full_c = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      mem_cnt_r;
  logic             rd_inflight_r;
  logic [1:0]       ob_cnt_r;
  logic [WIDTH-1:0] ob0_r;
  logic [WIDTH-1:0] ob1_r;
  logic [AW-1:0]    ram_a_r;
  logic [WIDTH-1:0] ram_d_r;

  logic             pop_s;
  logic             rd_go_s;
  logic             wr_go_s;
  logic             byp_s;
  logic             mem_wr_s;
  logic             app_s;
  logic [1:0]       ob_left_s;
  logic [2:0]       rd_occ_s;
  logic [WIDTH-1:0] app_data_s;

  // Arbitration: reads win the single SRAM port; nothing is issued while rst is high.
  always_comb begin
    pop_s     = !rst && (ob_cnt_r != 2'd0) && out_ready;
    ob_left_s = ob_cnt_r - {1'b0, pop_s};
    rd_occ_s  = {1'b0, ob_cnt_r} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
    rd_go_s   = !rst && (mem_cnt_r != {(AW+1){1'b0}}) && (rd_occ_s < 3'd2);
    in_ready  = !rst && (mem_cnt_r != mem_full_c) && !rd_go_s;
    wr_go_s   = in_valid && in_ready;
`ifdef SPF_BYPASS_EN
    byp_s     = (mem_cnt_r == {(AW+1){1'b0}}) && !rd_inflight_r && (ob_left_s < 2'd2);
`else
    byp_s     = 1'b0;
`endif
    mem_wr_s   = wr_go_s && !byp_s;
    app_s      = rd_inflight_r || (wr_go_s && byp_s);
    app_data_s = rd_inflight_r ? ram_q : in_data;
  end

  // SRAM port drive; address and data hold their last values on idle cycles.
  always_comb begin
    if (rd_go_s) begin
      ram_ceb = 1'b0;
      ram_web = 1'b1;
      ram_a   = rd_ptr_r;
      ram_d   = ram_d_r;
    end else if (mem_wr_s) begin
      ram_ceb = 1'b0;
      ram_web = 1'b0;
      ram_a   = wr_ptr_r;
      ram_d   = in_data;
    end else begin
      ram_ceb = 1'b1;
      ram_web = 1'b1;
      ram_a   = ram_a_r;
      ram_d   = ram_d_r;
    end
  end

  // Occupancy and head-of-queue outputs, all derived from registers.
  always_comb begin
    out_valid = (ob_cnt_r != 2'd0);
    out_data  = ob0_r;
    count     = {1'b0, mem_cnt_r} + {{(AW+1){1'b0}}, rd_inflight_r} + {{AW{1'b0}}, ob_cnt_r};
  end

  // Pointer, counter and output-buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      mem_cnt_r     <= {(AW+1){1'b0}};
      rd_inflight_r <= 1'b0;
      ob_cnt_r      <= 2'd0;
      ob0_r         <= {WIDTH{1'b0}};
      ob1_r         <= {WIDTH{1'b0}};
      ram_a_r       <= {AW{1'b0}};
      ram_d_r       <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r      <= wr_ptr_r + {{(AW-1){1'b0}}, mem_wr_s};
      rd_ptr_r      <= rd_ptr_r + {{(AW-1){1'b0}}, rd_go_s};
      mem_cnt_r     <= mem_cnt_r + {{AW{1'b0}}, mem_wr_s} - {{AW{1'b0}}, rd_go_s};
      rd_inflight_r <= rd_go_s;
      ram_a_r       <= ram_a;
      ram_d_r       <= ram_d;
      ob_cnt_r      <= ob_left_s + {1'b0, app_s};
      // New entry lands at the first free slot left after this cycle's pop.
      if (app_s && (ob_left_s == 2'd0)) begin
        ob0_r <= app_data_s;
      end else if (pop_s) begin
        ob0_r <= ob1_r;
      end else begin
        ob0_r <= ob0_r;
      end
      if (app_s && (ob_left_s != 2'd0)) begin
        ob1_r <= app_data_s;
      end else begin
        ob1_r <= ob1_r;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: SRAM model, queue-based reference, directed and random phases.
module tb_spram_fifo_ctrl;
  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef SPF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW+1:0]    count;
  logic             ram_ceb;
  logic             ram_web;
  logic [AW-1:0]    ram_a;
  logic [WIDTH-1:0] ram_d;
  logic [WIDTH-1:0] ram_q = '0;
  logic [WIDTH-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;

  spram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: write on WEB=0, read data returns one cycle later.
  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) mem[ram_a] <= ram_d;
      else ram_q <= mem[ram_a];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: global FIFO queue plus per-stage occupancy numbers.
  logic [WIDTH-1:0] q[$];
  int m_sram = 0, m_buf = 0, m_fl = 0, m_ra = 0, m_wa = 0;
  int e_pop, e_rd, e_ir, e_wr, e_byp;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_sram = 0; m_buf = 0; m_fl = 0; m_ra = 0; m_wa = 0;
    end else begin
      e_pop = (m_buf > 0 && out_ready) ? 1 : 0;
      e_rd  = (m_sram > 0 && (m_buf + m_fl - e_pop) < 2) ? 1 : 0;
      e_ir  = (m_sram < DEPTH && e_rd == 0) ? 1 : 0;
      e_wr  = (in_valid && e_ir == 1) ? 1 : 0;
`ifdef SPF_BYPASS_EN
      e_byp = (m_sram == 0 && m_fl == 0 && (m_buf - e_pop) < 2) ? 1 : 0;
`else
      e_byp = 0;
`endif
      check("out_valid", 64'(out_valid), 64'(m_buf > 0));
      check("count", 64'(count), 64'(q.size()));
      if (m_buf > 0) check("out_data", out_data, q[0]);
      check("in_ready", 64'(in_ready), 64'(e_ir));
      check("ram_ceb", 64'(ram_ceb), 64'(!(e_rd == 1 || (e_wr == 1 && e_byp == 0))));
      if (e_rd == 1) begin
        check("ram_web_rd", 64'(ram_web), 64'd1);
        check("ram_a_rd", 64'(ram_a), 64'(m_ra));
      end else if (e_wr == 1 && e_byp == 0) begin
        check("ram_web_wr", 64'(ram_web), 64'd0);
        check("ram_a_wr", 64'(ram_a), 64'(m_wa));
        check("ram_d_wr", ram_d, in_data);
      end
      if (e_pop == 1) void'(q.pop_front());
      if (e_wr == 1) q.push_back(in_data);
      m_buf  = m_buf - e_pop + m_fl + ((e_wr == 1 && e_byp == 1) ? 1 : 0);
      m_fl   = e_rd;
      m_sram = m_sram + ((e_wr == 1 && e_byp == 0) ? 1 : 0) - e_rd;
      if (e_rd == 1) m_ra = (m_ra + 1) % DEPTH;
      if (e_wr == 1 && e_byp == 0) m_wa = (m_wa + 1) % DEPTH;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] n;
  logic             acc;
  int               acc_n;
  int               found;
  int               pv, pr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: no SRAM access, empty, ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ceb", 64'(ram_ceb), 64'd1);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_count", 64'(count), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);
    end

    // Single push latency into an empty FIFO.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check("lat_out_valid", 64'(out_valid), 64'(k == LAT));
      if (k < LAT) begin
        @(posedge clk); #1;
      end
    end
    check("lat_out_data", out_data, 64'hDEADBEEF_CAFEF00D);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Fill to DEPTH+2 with the consumer stalled.
    val = 64'd1; acc_n = 0;
    for (int c = 0; c < 200 && acc_n < 18; c++) begin
      in_valid = 1'b1; in_data = val;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin val = val + 64'd1; acc_n++; end
    end
    in_valid = 1'b0;
    check("fill_accepted", 64'(acc_n), 64'd18);
    @(negedge clk);
    check("full_count", 64'(count), 64'd18);
    check("full_in_ready", 64'(in_ready), 64'd0);

    // Stream with both sides active: no bubbles, pushes stall while SRAM drains.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = val; out_ready = 1'b1; n = 64'd1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", out_data, n);
      if (c < 16) check("stream_stall", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      if (out_valid) n = n + 64'd1;
      @(posedge clk); #1;
      if (acc) begin val = val + 64'd1; in_data = val; end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        check("drain_order", out_data, n);
        n = n + 64'd1;
      end
      @(posedge clk); #1;
      if (acc) begin val = val + 64'd1; in_data = val; end
      if (c == 5) in_valid = 1'b0;
    end
    check("drain_all", n, val);

    // Reset while a read is in flight.
    found = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom % 2); out_ready = ($urandom % 4) == 0;
      in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      if (m_fl == 1 && q.size() >= 3) begin found = 1; break; end
    end
    check("rst_inflight_found", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Random traffic against the model.
    pv = 50; pr = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      in_valid  = ($urandom % 100) < pv;
      out_ready = ($urandom % 100) < pr;
      in_data   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
